// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
package mul_arbiter_pkg;

    localparam int DEFAULT_N_BIT = 4;
    localparam int ID_W          = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul.sv
// Combinational N_BIT x N_BIT array multiplier, unsigned or two's-complement.
module mul #(
    parameter int N_BIT    = 4,
    parameter int RES_SIZE = 2 * N_BIT
) (
    input  logic [N_BIT-1:0]    a,
    input  logic [N_BIT-1:0]    b,
    input  logic                mul_type,
    output logic [RES_SIZE-1:0] product
);

    logic [RES_SIZE-1:0] a_ext;
    logic [RES_SIZE-1:0] b_ext;
    logic [RES_SIZE-1:0] acc [0:RES_SIZE];

    // Extending both operands to full width makes the modular product correct for signed mode too.
    assign a_ext = mul_type ? {{(RES_SIZE-N_BIT){a[N_BIT-1]}}, a} : {{(RES_SIZE-N_BIT){1'b0}}, a};
    assign b_ext = mul_type ? {{(RES_SIZE-N_BIT){b[N_BIT-1]}}, b} : {{(RES_SIZE-N_BIT){1'b0}}, b};

    assign acc[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < RES_SIZE; gi++) begin : g_pp
            logic [RES_SIZE-1:0] pp;
            assign pp         = b_ext[gi] ? (a_ext << gi) : '0;
            assign acc[gi+1]  = acc[gi] + pp;
        end
    endgenerate

    assign product = acc[RES_SIZE];

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one multiplier between two requesters with a tagged,
// backpressured response channel.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int N_BIT    = DEFAULT_N_BIT,
    parameter int RES_SIZE = 2 * N_BIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [N_BIT-1:0]    req0_a,
    input  logic [N_BIT-1:0]    req0_b,
    input  logic                req0_signed,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [N_BIT-1:0]    req1_a,
    input  logic [N_BIT-1:0]    req1_b,
    input  logic                req1_signed,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [ID_W-1:0]     resp_id,
    output logic [RES_SIZE-1:0] resp_product,
    output logic                busy
);

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     last_id_reg;
    logic [N_BIT-1:0]    op_a_reg, op_b_reg;
    logic                op_signed_reg;
    logic [ID_W-1:0]     op_id_reg;
    logic [RES_SIZE-1:0] resp_product_reg;
    logic [ID_W-1:0]     resp_id_reg;
    logic [RES_SIZE-1:0] mul_product;
    logic                grant_valid;
    logic [ID_W-1:0]     grant_id;

    always_comb begin
        state_next  = state_reg;
        grant_valid = 1'b0;
        grant_id    = '0;
        case (state_reg)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_valid = 1'b1;
                    // Under contention the requester that did not win last time goes first.
                    if (req0_valid && req1_valid)
                        grant_id = ~last_id_reg;
                    else
                        grant_id = req1_valid;
                    state_next = CALC;
                end
            end
            CALC:    state_next = DONE;
            DONE:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        req0_ready = grant_valid && (grant_id == 1'b0);
        req1_ready = grant_valid && (grant_id == 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_id_reg   <= 1'b1;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            op_signed_reg <= 1'b0;
            op_id_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_valid) begin
                last_id_reg   <= grant_id;
                op_id_reg     <= grant_id;
                op_a_reg      <= (grant_id == 1'b1) ? req1_a      : req0_a;
                op_b_reg      <= (grant_id == 1'b1) ? req1_b      : req0_b;
                op_signed_reg <= (grant_id == 1'b1) ? req1_signed : req0_signed;
            end
        end
    end

    mul #(
        .N_BIT    (N_BIT),
        .RES_SIZE (RES_SIZE)
    ) u_mul (
        .a        (op_a_reg),
        .b        (op_b_reg),
        .mul_type (op_signed_reg),
        .product  (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_product_reg <= '0;
            resp_id_reg      <= '0;
        end else if (state_reg == CALC) begin
            resp_product_reg <= mul_product;
            resp_id_reg      <= op_id_reg;
        end
    end

    assign resp_valid   = (state_reg == DONE);
    assign resp_product = resp_product_reg;
    assign resp_id      = resp_id_reg;
    assign busy         = (state_reg != IDLE);

endmodule
